pipe_stage_skid: RTL and testbench

//   Generic elastic pipeline-stage register. Successor to the fixed MEM/WB latch.

---
 rtl/pipe_stage_skid.sv | 124 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, flush, and zeroed bubble control.
// Optional stall counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 69,
  parameter int unsigned CTRL_W = 2
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic              in_ready_q,   in_ready_d;
  logic              accept_c;
  logic              deliver_c;

  assign accept_c  = in_valid & in_ready_q;
  assign deliver_c = main_valid_q & out_ready;

  // Entry update: main refills from skid first, else from input; skid catches input on a stalled main.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;

    if (flush) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || deliver_c) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_ctrl_d  = skid_ctrl_q;
        skid_valid_d = 1'b0;
      end else if (accept_c) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_ctrl_d  = in_ctrl;
      end else begin
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
      end
    end else if (accept_c) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_ctrl_d  = in_ctrl;
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed and randomized steps checked against a 2-deep FIFO model.
module tb_pipe_stage_skid;

  localparam int unsigned DATA_W = 69;
  localparam int unsigned CTRL_W = 2;
`ifdef PIPE_STAGE_STALL_CNT_EN
  localparam int unsigned CNT_W  = 4;
`endif

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } item_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  // Reference: the stage is a FIFO of capacity two; flush and reset empty it.
  item_t       mq[$];
  item_t       sent_q[$];
  item_t       recv_q[$];
  int unsigned m_stall;
  bit          last_acc;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [CTRL_W-1:0] exp_ctrl;
    exp_ctrl = (mq.size() > 0) ? mq[0].ctrl : '0;
    chk({tag, ".out_valid"}, DATA_W'(out_valid), DATA_W'(mq.size() > 0));
    chk({tag, ".in_ready"},  DATA_W'(in_ready),  DATA_W'(mq.size() < 2));
    chk({tag, ".out_ctrl"},  DATA_W'(out_ctrl),  DATA_W'(exp_ctrl));
    if (mq.size() > 0) chk({tag, ".out_data"}, out_data, mq[0].data);
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk({tag, ".stall_cnt"}, DATA_W'(stall_cnt), DATA_W'(m_stall));
`endif
  endtask

  task automatic step(input string tag);
    bit    acc;
    bit    del;
    item_t it;
    if (out_valid === 1'b1 && out_ready) recv_q.push_back({out_ctrl, out_data});
    @(posedge clk);
    last_acc = 1'b0;
    if (!reset) begin
      mq.delete();
      m_stall = 0;
    end else begin
      if (mq.size() > 0 && !out_ready && m_stall < 32'((1 << 4) - 1)) m_stall++;
      acc = in_valid && (mq.size() < 2);
      del = (mq.size() > 0) && out_ready;
      last_acc = acc;
      if (flush) begin
        mq.delete();
      end else begin
        if (del) void'(mq.pop_front());
        if (acc) begin
          it.ctrl = in_ctrl;
          it.data = in_data;
          mq.push_back(it);
          sent_q.push_back(it);
        end
      end
    end
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return DATA_W'({$urandom, $urandom, 5'($urandom)});
  endfunction

  initial begin
    bit hold;
    checks    = 0;
    errors    = 0;
    m_stall   = 0;
    last_acc  = 1'b0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;

    step("reset0");
    step("reset1");
    chk("reset.out_valid", DATA_W'(out_valid), '0);
    chk("reset.in_ready",  DATA_W'(in_ready),  DATA_W'(1));
    #1 reset = 1'b1;

    // Streaming 1..8 with out_ready held high.
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_ctrl  = 2'b01;
      in_data  = DATA_W'(k);
      step("stream");
      chk("stream.data_lat1", out_data, DATA_W'(k));
    end
    in_valid = 1'b0;
    step("stream_tail");
    step("stream_idle");

    // A,B,C into a stalled stage, then release.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 2'b11;
    in_data   = DATA_W'(32'hA);
    step("fill_a");
    in_data   = DATA_W'(32'hB);
    step("fill_b");
    chk("fill.in_ready_low", DATA_W'(in_ready), '0);
    in_data   = DATA_W'(32'hC);
    step("stall_c0");
    step("stall_c1");
    chk("stall.main_a", out_data, DATA_W'(32'hA));
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (last_acc) in_valid = 1'b0;
      step("drain");
    end

    // Flush with main=A, skid=B and C on the input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 2'b01;
    in_data   = DATA_W'(32'hA);
    step("fl_a");
    in_data   = DATA_W'(32'hB);
    step("fl_b");
    in_data   = DATA_W'(32'hC);
    flush     = 1'b1;
    step("flush");
    chk("flush.out_ctrl", DATA_W'(out_ctrl), '0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) step("post_flush");

    // Randomized stream with random out_ready; upstream holds data while stalled.
    sent_q.delete();
    recv_q.delete();
    hold = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      if (!hold) begin
        in_data  = rnd_data();
        in_ctrl  = CTRL_W'($urandom);
        in_valid = ($urandom_range(0, 9) < 7);
      end
      out_ready = $urandom_range(0, 1) == 1;
      step("rand");
      hold = in_valid && !last_acc;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step("rand_drain");
    chk("rand.count", DATA_W'(recv_q.size()), DATA_W'(sent_q.size()));
    for (int k = 0; k < sent_q.size() && k < recv_q.size(); k++) begin
      chk("rand.order", recv_q[k].data, sent_q[k].data);
    end

    // Reset mid-stream with skid full and an input offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DATA_W'(32'h11);
    step("rst_fill0");
    in_data   = DATA_W'(32'h22);
    step("rst_fill1");
    in_data   = DATA_W'(32'h33);
    out_ready = 1'b1;
    reset     = 1'b0;
    step("mid_reset");
    chk("mid_reset.out_ctrl", DATA_W'(out_ctrl), '0);
    reset     = 1'b1;
    in_valid  = 1'b0;
    step("post_reset");

`ifdef PIPE_STAGE_STALL_CNT_EN
    // Stall counter saturation and flush immunity.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DATA_W'(32'h55);
    step("cnt_load");
    in_valid  = 1'b0;
    for (int k = 0; k < 20; k++) step("cnt_stall");
    chk("cnt.saturated", DATA_W'(stall_cnt), DATA_W'(15));
    flush = 1'b1;
    step("cnt_flush");
    flush = 1'b0;
    step("cnt_after_flush");
    chk("cnt.after_flush", DATA_W'(stall_cnt), DATA_W'(15));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
